// File: rtl/gb_cpu_interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// gb_cpu_interrupt_ctrl
//
// Interrupt-side companion to the CPU instruction scheduler. It owns the IME
// flag and the delayed-EI state. It produces the 5 M-cycle interrupt dispatch
// sequence and the HALT state. While dispatch_o is high, the scheduler's
// control stream is overridden by this block.
//
// Optional feature macro: GB_CPU_HALT_BUG_EN
//   Defined     : HALT executed with IME = 0 and an interrupt already pending
//                 pulses halt_bug_o for one cycle, and the state stays IDLE.
//   Not defined : halt_bug_o is tied to 0, and the same case stays IDLE.
//
// Ports
//   clk              in   1   M-cycle clock
//   reset            in   1   synchronous, active-high
//   instr_boundary   in   1   final M-cycle of the current instruction
//   ei_i             in   1   EI executed
//   di_i             in   1   DI executed
//   reti_i           in   1   RETI executed
//   halt_i           in   1   HALT executed (qualified by instr_boundary)
//   if_i             in   5   IF register
//   ie_i             in   5   IE register (low 5 bits)
//   ime_o            out  1   interrupt master enable
//   halted_o         out  1   CPU halted, scheduler stalls
//   dispatch_o       out  1   dispatch sequence active
//   dispatch_cycle_o out  3   dispatch M-cycle 5..1, 0 when idle
//   vector_o         out 16   jump target, valid in dispatch cycles 2 and 1
//   if_clear_o       out  5   one-hot IF bit to clear (single-cycle pulse)
//   halt_bug_o       out  1   suppress next PC increment (single-cycle pulse)
// -----------------------------------------------------------------------------
module gb_cpu_interrupt_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_boundary,
  input  logic        ei_i,
  input  logic        di_i,
  input  logic        reti_i,
  input  logic        halt_i,
  input  logic [4:0]  if_i,
  input  logic [4:0]  ie_i,
  output logic        ime_o,
  output logic        halted_o,
  output logic        dispatch_o,
  output logic [2:0]  dispatch_cycle_o,
  output logic [15:0] vector_o,
  output logic [4:0]  if_clear_o,
  output logic        halt_bug_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HALTED   = 2'd1,
    ST_DISPATCH = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        ime_reg, ime_next;
  logic        ei_pending_reg, ei_pending_next;
  logic        halted_reg, halted_next;
  logic        dispatch_reg, dispatch_next;
  logic [2:0]  cycle_reg, cycle_next;
  logic [15:0] vector_reg, vector_next;
  logic [4:0]  if_clear_reg, if_clear_next;
`ifdef GB_CPU_HALT_BUG_EN
  logic        halt_bug_reg, halt_bug_next;
`endif

  // ---------------------------------------------------------------------------
  // Pending requests and lowest-bit-wins priority selection
  // ---------------------------------------------------------------------------
  logic [4:0]  pending;
  logic        any_pending;
  logic [4:0]  prio_onehot;
  logic [15:0] vec_term [5];
  logic [15:0] prio_vector;

  assign pending     = ie_i & if_i;
  assign any_pending = |pending;
  // Two's-complement trick isolates the lowest set bit.
  assign prio_onehot = pending & (~pending + 5'd1);

  // Vectors are spaced 8 bytes apart starting at 0x0040.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_vec
      assign vec_term[gi] = prio_onehot[gi] ? (16'h0040 + 16'(gi * 8)) : 16'h0000;
    end
  endgenerate

  // Only one term can be nonzero, so OR-ing them selects the vector; with
  // nothing pending the result is 0x0000, which is the cancel vector.
  always_comb begin
    prio_vector = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      prio_vector = prio_vector | vec_term[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    ime_next        = ime_reg;
    ei_pending_next = ei_pending_reg;
    cycle_next      = cycle_reg;
    vector_next     = vector_reg;
    if_clear_next   = 5'd0;
`ifdef GB_CPU_HALT_BUG_EN
    halt_bug_next   = 1'b0;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (instr_boundary && ime_reg && any_pending) begin
          // Dispatch start outranks every instruction-side IME event.
          state_next      = ST_DISPATCH;
          cycle_next      = 3'd5;
          ime_next        = 1'b0;
          ei_pending_next = 1'b0;
          vector_next     = 16'h0000;
        end else begin
          // Later assignments win: delayed-EI promotion < ei < reti < di.
          // ei_pending is a register, so a promotion can only happen on a
          // boundary strictly after the one that sampled ei_i.
          if (instr_boundary && ei_pending_reg) begin
            ime_next        = 1'b1;
            ei_pending_next = 1'b0;
          end
          if (ei_i) begin
            ei_pending_next = 1'b1;
          end
          if (reti_i) begin
            ime_next = 1'b1;
          end
          if (di_i) begin
            ime_next        = 1'b0;
            ei_pending_next = 1'b0;
          end
          if (instr_boundary && halt_i) begin
            if (!any_pending) begin
              state_next = ST_HALTED;
            end
`ifdef GB_CPU_HALT_BUG_EN
            else if (!ime_reg) begin
              halt_bug_next = 1'b1;
            end
`endif
          end
        end
      end

      ST_HALTED: begin
        // Wake-up ignores IME; IME only decides whether we dispatch.
        if (any_pending) begin
          if (ime_reg) begin
            state_next      = ST_DISPATCH;
            cycle_next      = 3'd5;
            ime_next        = 1'b0;
            ei_pending_next = 1'b0;
            vector_next     = 16'h0000;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      ST_DISPATCH: begin
        cycle_next = cycle_reg - 3'd1;
        if (cycle_reg == 3'd3) begin
          // Late re-sample: a request withdrawn during the SP/PC-high pushes
          // cancels the jump to 0x0000 and clears no IF bit.
          vector_next   = prio_vector;
          if_clear_next = prio_onehot;
        end
        if (cycle_reg == 3'd1) begin
          state_next = ST_IDLE;
          cycle_next = 3'd0;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cycle_next = 3'd0;
      end
    endcase

    halted_next   = (state_next == ST_HALTED);
    dispatch_next = (state_next == ST_DISPATCH);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      ime_reg        <= 1'b0;
      ei_pending_reg <= 1'b0;
      halted_reg     <= 1'b0;
      dispatch_reg   <= 1'b0;
      cycle_reg      <= 3'd0;
      vector_reg     <= 16'h0000;
      if_clear_reg   <= 5'd0;
    end else begin
      state_reg      <= state_next;
      ime_reg        <= ime_next;
      ei_pending_reg <= ei_pending_next;
      halted_reg     <= halted_next;
      dispatch_reg   <= dispatch_next;
      cycle_reg      <= cycle_next;
      vector_reg     <= vector_next;
      if_clear_reg   <= if_clear_next;
    end
  end

`ifdef GB_CPU_HALT_BUG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_bug_reg <= 1'b0;
    end else begin
      halt_bug_reg <= halt_bug_next;
    end
  end
  assign halt_bug_o = halt_bug_reg;
`else
  assign halt_bug_o = 1'b0;
`endif

  assign ime_o            = ime_reg;
  assign halted_o         = halted_reg;
  assign dispatch_o       = dispatch_reg;
  assign dispatch_cycle_o = cycle_reg;
  assign vector_o         = vector_reg;
  assign if_clear_o       = if_clear_reg;

endmodule
